// File: rtl/tictactoe_board_writer.sv
// Tic-tac-toe board owner: sequences turns, validates and writes moves,
// auto-plays the lowest empty cell when a turn times out, and latches the
// game result reported by the external combinational game-end detector.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   new_game_i            start/restart a game (pulse or level)
//   move_valid_i          move request, move_pos_i = cell 0..8 (row-major)
//   move_ready_o          high while waiting for a move
//   move_accept_o         pulse: requested move written
//   move_reject_o         pulse: requested move illegal
//   timeout_o             pulse: auto-move written
//   current_board_o       9 cells of {occupied, player}
//   turn_o                player to move
//   move_count_o          filled cells 0..9
//   game_end_i/tie_i/winner_i  detector result for current_board_o
//   result_valid_o        high once the game is over
//   tie_o, winner_player_o latched result
module tictactoe_board_writer #(
  parameter int unsigned TURN_TIMEOUT = 50_000_000,
  parameter logic        FIRST_PLAYER = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            new_game_i,
  input  logic            move_valid_i,
  input  logic [3:0]      move_pos_i,
  output logic            move_ready_o,
  output logic            move_accept_o,
  output logic            move_reject_o,
  output logic            timeout_o,
  output logic [8:0][1:0] current_board_o,
  output logic            turn_o,
  output logic [3:0]      move_count_o,
  input  logic            game_end_i,
  input  logic            tie_i,
  input  logic            winner_i,
  output logic            result_valid_o,
  output logic            tie_o,
  output logic            winner_player_o
);

  localparam int unsigned TIMER_W = $clog2(TURN_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [8:0][1:0]    board_q, board_d;
  logic               turn_q, turn_d;
  logic [3:0]         count_q, count_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               accept_q, accept_d;
  logic               reject_q, reject_d;
  logic               timeout_q, timeout_d;
  logic               ready_q, ready_d;
  logic               rvalid_q, rvalid_d;
  logic               tie_q, tie_d;
  logic               winner_q, winner_d;

  logic               target_busy;
  logic               move_legal;
  logic               auto_found;
  logic [3:0]         auto_idx;
  logic               wr_en;
  logic [3:0]         wr_idx;

  // Move legality and lowest empty cell for the auto-move.
  always_comb begin
    target_busy = 1'b0;
    auto_found  = 1'b0;
    auto_idx    = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (move_pos_i == 4'(i)) target_busy = board_q[i][1];
    end
    // Descending scan so the last hit is the lowest empty index.
    for (int i = 8; i >= 0; i--) begin
      if (!board_q[i][1]) begin
        auto_found = 1'b1;
        auto_idx   = 4'(i);
      end
    end
    move_legal = move_valid_i && (move_pos_i <= 4'd8) && !target_busy;
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    count_d   = count_q;
    timer_d   = timer_q;
    accept_d  = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    tie_d     = tie_q;
    winner_d  = winner_q;
    wr_en     = 1'b0;
    wr_idx    = 4'd0;

    if (new_game_i) begin
      state_d  = S_WAIT;
      board_d  = '0;
      turn_d   = FIRST_PLAYER;
      count_d  = 4'd0;
      timer_d  = '0;
      tie_d    = 1'b0;
      winner_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (move_legal) begin
            wr_en    = 1'b1;
            wr_idx   = move_pos_i;
            accept_d = 1'b1;
            timer_d  = '0;
            state_d  = S_CHECK;
          end else begin
            // An illegal request never resets the turn timer.
            reject_d = move_valid_i;
            if (timer_q == TIMER_LAST) begin
              wr_en     = auto_found;
              wr_idx    = auto_idx;
              timeout_d = 1'b1;
              timer_d   = '0;
              state_d   = S_CHECK;
            end else begin
              timer_d = timer_q + TIMER_W'(1);
            end
          end
        end
        S_CHECK: begin
          // A full board ends the game even if the detector misses it.
          if (game_end_i || (count_q == 4'd9)) begin
            tie_d    = game_end_i ? (tie_i && !winner_i) : 1'b1;
            winner_d = turn_q;
            state_d  = S_OVER;
          end else begin
            turn_d  = !turn_q;
            state_d = S_WAIT;
          end
        end
        default: ;
      endcase
    end

    if (wr_en) begin
      count_d = count_q + 4'd1;
      for (int i = 0; i < 9; i++) begin
        if (wr_idx == 4'(i)) board_d[i] = {1'b1, turn_q};
      end
    end

    ready_d  = (state_d == S_WAIT);
    rvalid_d = (state_d == S_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      turn_q    <= FIRST_PLAYER;
      count_q   <= 4'd0;
      timer_q   <= '0;
      accept_q  <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      tie_q     <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      accept_q  <= accept_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      tie_q     <= tie_d;
      winner_q  <= winner_d;
    end
  end

  assign move_ready_o    = ready_q;
  assign move_accept_o   = accept_q;
  assign move_reject_o   = reject_q;
  assign timeout_o       = timeout_q;
  assign current_board_o = board_q;
  assign turn_o          = turn_q;
  assign move_count_o    = count_q;
  assign result_valid_o  = rvalid_q;
  assign tie_o           = tie_q;
  assign winner_player_o = winner_q;

endmodule

// File: tb/tb_tictactoe_board_writer.sv
// Self-checking bench for tictactoe_board_writer: directed vector table,
// hand-written timeout / tie / reset sequences, and random play against a
// reference model built from the game rules.
module tb_tictactoe_board_writer;

  localparam int TO = 8;

  logic            clk;
  logic            rst_i, new_game_i, move_valid_i;
  logic [3:0]      move_pos_i;
  logic            move_ready_o, move_accept_o, move_reject_o, timeout_o;
  logic [8:0][1:0] current_board_o;
  logic            turn_o;
  logic [3:0]      move_count_o;
  logic            game_end_i, tie_i, winner_i;
  logic            result_valid_o, tie_o, winner_player_o;
  logic            det_fault;

  int n_tests = 0;
  int n_fail  = 0;

  tictactoe_board_writer #(.TURN_TIMEOUT(TO), .FIRST_PLAYER(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_i), .new_game_i(new_game_i),
    .move_valid_i(move_valid_i), .move_pos_i(move_pos_i),
    .move_ready_o(move_ready_o), .move_accept_o(move_accept_o),
    .move_reject_o(move_reject_o), .timeout_o(timeout_o),
    .current_board_o(current_board_o), .turn_o(turn_o),
    .move_count_o(move_count_o), .game_end_i(game_end_i), .tie_i(tie_i),
    .winner_i(winner_i), .result_valid_o(result_valid_o), .tie_o(tie_o),
    .winner_player_o(winner_player_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lc(int l, int k);
    int t[24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};
    return t[l*3+k];
  endfunction

  // Detector on the DUT board; det_fault suppresses game_end_i.
  logic d_win, d_full;
  always_comb begin
    d_win  = 1'b0;
    d_full = 1'b1;
    for (int l = 0; l < 8; l++) begin
      if (current_board_o[lc(l,0)][1] &&
          current_board_o[lc(l,1)] == current_board_o[lc(l,0)] &&
          current_board_o[lc(l,2)] == current_board_o[lc(l,0)])
        d_win = 1'b1;
    end
    for (int i = 0; i < 9; i++) if (!current_board_o[i][1]) d_full = 1'b0;
    winner_i   = d_win;
    tie_i      = d_full && !d_win;
    game_end_i = (d_win || d_full) && !det_fault;
  end

  function automatic logic [28:0] pk(logic rdy, logic acc, logic rej, logic to,
                                     logic turn, logic [3:0] cnt, logic rv,
                                     logic tie, logic win, logic [17:0] b);
    return {rdy, acc, rej, to, turn, cnt, rv, tie, win, b};
  endfunction

  function automatic logic [28:0] dut_pk();
    return {move_ready_o, move_accept_o, move_reject_o, timeout_o, turn_o,
            move_count_o, result_valid_o, tie_o, winner_player_o, current_board_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic ng, input logic mv, input logic [3:0] p);
    rst_i = r; new_game_i = ng; move_valid_i = mv; move_pos_i = p;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (rules-level) ----------------
  int   mb[9];          // 0 empty, 1 player0, 2 player1
  int   mph;            // 0 idle, 1 waiting, 2 checking, 3 over
  int   mturn, mcount, mtimer;
  logic macc, mrej, mto, mtie, mwin;

  function automatic bit m_won();
    for (int l = 0; l < 8; l++)
      if (mb[lc(l,0)] != 0 && mb[lc(l,0)] == mb[lc(l,1)] && mb[lc(l,0)] == mb[lc(l,2)])
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    foreach (mb[i]) mb[i] = 0;
    mturn = 0; mcount = 0; mtimer = 0; mtie = 0; mwin = 0;
  endtask

  task automatic model_step(input logic r, input logic ng, input logic mv, input int p);
    bit full, w;
    macc = 0; mrej = 0; mto = 0;
    if (r) begin
      m_clear(); mph = 0;
    end else if (ng) begin
      m_clear(); mph = 1;
    end else if (mph == 1) begin
      if (mv && p <= 8 && mb[p] == 0) begin
        mb[p] = mturn + 1; mcount++; mtimer = 0; macc = 1; mph = 2;
      end else begin
        mrej = mv;
        if (mtimer == TO - 1) begin
          for (int i = 0; i < 9; i++) if (mb[i] == 0) begin mb[i] = mturn + 1; break; end
          mcount++; mtimer = 0; mto = 1; mph = 2;
        end else mtimer++;
      end
    end else if (mph == 2) begin
      w = m_won();
      full = (mcount == 9);
      if (w || full) begin
        mtie = !w; mwin = mturn[0]; mph = 3;
      end else begin
        mturn = 1 - mturn; mph = 1;
      end
    end
  endtask

  function automatic logic [28:0] model_pk();
    logic [17:0] b;
    for (int i = 0; i < 9; i++)
      b[2*i +: 2] = (mb[i] == 0) ? 2'b00 : (mb[i] == 1) ? 2'b10 : 2'b11;
    return pk(mph == 1, macc, mrej, mto, mturn[0], 4'(mcount), mph == 3, mtie, mwin, b);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, ng, mv;
    logic [3:0]  pos;
    logic [28:0] exp;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic r, input logic ng, input logic mv, input logic [3:0] p,
                     input logic [28:0] e);
    vec_t v;
    v.rst = r; v.ng = ng; v.mv = mv; v.pos = p; v.exp = e;
    vq.push_back(v);
  endtask

  // ---------------- hand-written sequences ----------------
  task automatic play_tie(input logic fault);
    int order[9] = '{0,1,2,4,3,5,7,6,8};
    det_fault = fault;
    tick(0, 1, 0, 0);
    for (int k = 0; k < 9; k++) begin
      tick(0, 0, 1, 4'(order[k]));
      chk($sformatf("tie_acc%0d", k), {move_accept_o, move_count_o}, {1'b1, 4'(k+1)});
      tick(0, 0, 0, 0);
    end
    chk("tie_result", {result_valid_o, tie_o, move_count_o, move_ready_o},
        {1'b1, 1'b1, 4'd9, 1'b0});
    // Reset while in the final state.
    tick(1, 0, 1, 0);
    chk("rst_in_over", 32'(dut_pk()), 32'(pk(0,0,0,0,0,4'd0,0,0,0,18'd0)));
    det_fault = 1'b0;
  endtask

  task automatic timeout_case(input int variant);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 0, 0);
    for (int k = 1; k < TO; k++) begin
      tick(0, 0, 0, 0);
      chk($sformatf("to_wait%0d_%0d", variant, k), {timeout_o, move_count_o}, {1'b0, 4'd2});
    end
    case (variant)
      0: begin
        tick(0, 0, 0, 0);
        chk("to_auto", {move_accept_o, move_reject_o, timeout_o, move_count_o,
                        current_board_o[2]}, {3'b001, 4'd3, 2'b10});
      end
      1: begin
        tick(0, 0, 1, 5);
        chk("to_legal_wins", {move_accept_o, move_reject_o, timeout_o, move_count_o,
                              current_board_o[2], current_board_o[5]},
            {3'b100, 4'd3, 2'b00, 2'b10});
      end
      default: begin
        tick(0, 0, 1, 0);
        chk("to_reject_auto", {move_accept_o, move_reject_o, timeout_o, move_count_o,
                               current_board_o[2]}, {3'b011, 4'd3, 2'b10});
      end
    endcase
  endtask

  initial begin
    logic [17:0] b0, ba, bb, bc, bd, be, bf;
    det_fault = 1'b0;
    rst_i = 1'b1; new_game_i = 1'b0; move_valid_i = 1'b0; move_pos_i = 4'd0;

    b0 = 18'b000000000000000000;
    ba = 18'b000000000000000010;
    bb = 18'b000000000011000010;
    bc = 18'b000000000011001010;
    bd = 18'b000000001111001010;
    be = 18'b000000001111101010;
    bf = 18'b000000001000000000;

    //    rst ng mv pos      rdy acc rej to turn cnt rv tie win board
    add(1, 0, 0, 0,  pk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, b0));
    add(0, 1, 0, 0,  pk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, b0));
    add(0, 0, 1, 0,  pk(0, 1, 0, 0, 0, 4'd1, 0, 0, 0, ba));
    add(0, 0, 0, 0,  pk(1, 0, 0, 0, 1, 4'd1, 0, 0, 0, ba));
    add(0, 0, 1, 3,  pk(0, 1, 0, 0, 1, 4'd2, 0, 0, 0, bb));
    add(0, 0, 0, 0,  pk(1, 0, 0, 0, 0, 4'd2, 0, 0, 0, bb));
    add(0, 0, 1, 1,  pk(0, 1, 0, 0, 0, 4'd3, 0, 0, 0, bc));
    add(0, 0, 0, 0,  pk(1, 0, 0, 0, 1, 4'd3, 0, 0, 0, bc));
    add(0, 0, 1, 4,  pk(0, 1, 0, 0, 1, 4'd4, 0, 0, 0, bd));
    add(0, 0, 0, 0,  pk(1, 0, 0, 0, 0, 4'd4, 0, 0, 0, bd));
    add(0, 0, 1, 2,  pk(0, 1, 0, 0, 0, 4'd5, 0, 0, 0, be));
    add(0, 0, 0, 0,  pk(0, 0, 0, 0, 0, 4'd5, 1, 0, 0, be));
    add(0, 0, 1, 5,  pk(0, 0, 0, 0, 0, 4'd5, 1, 0, 0, be));
    add(0, 1, 1, 0,  pk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, b0));
    add(0, 0, 1, 4,  pk(0, 1, 0, 0, 0, 4'd1, 0, 0, 0, bf));
    add(0, 0, 0, 0,  pk(1, 0, 0, 0, 1, 4'd1, 0, 0, 0, bf));
    add(0, 0, 1, 4,  pk(1, 0, 1, 0, 1, 4'd1, 0, 0, 0, bf));
    add(0, 0, 1, 12, pk(1, 0, 1, 0, 1, 4'd1, 0, 0, 0, bf));
    add(0, 0, 0, 0,  pk(1, 0, 0, 0, 1, 4'd1, 0, 0, 0, bf));
    add(0, 1, 1, 0,  pk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, b0));
    add(0, 0, 1, 0,  pk(0, 1, 0, 0, 0, 4'd1, 0, 0, 0, ba));
    add(1, 0, 1, 1,  pk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, b0));
    add(0, 0, 1, 0,  pk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, b0));
    add(0, 1, 0, 0,  pk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, b0));
    add(0, 0, 1, 0,  pk(0, 1, 0, 0, 0, 4'd1, 0, 0, 0, ba));
    add(0, 0, 1, 1,  pk(1, 0, 0, 0, 1, 4'd1, 0, 0, 0, ba));

    foreach (vq[i]) begin
      tick(vq[i].rst, vq[i].ng, vq[i].mv, vq[i].pos);
      chk($sformatf("vec%0d", i), 32'(dut_pk()), 32'(vq[i].exp));
    end

    timeout_case(0);
    timeout_case(1);
    timeout_case(2);
    play_tie(1'b0);
    play_tie(1'b1);

    // Random play against the reference model.
    tick(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      logic r, ng, mv;
      logic [3:0] p;
      r  = ($urandom_range(0, 199) == 0);
      ng = ($urandom_range(0, 39) == 0);
      mv = ($urandom_range(0, 2) == 0);
      p  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      model_step(r, ng, mv, int'(p));
      tick(r, ng, mv, p);
      chk($sformatf("rand%0d", c), 32'(dut_pk()), 32'(model_pk()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
